// File: rtl/reg_fifo.sv
// reg_fifo: parametrised FIFO of DEPTH words of WIDTH bits.
// It replaces a single enabled state register wherever buffering is needed
// between a producer and a consumer. Full and empty come from an explicit
// occupancy count, not from comparing the pointers, so DEPTH can be any value
// from 1 to 1024. The design also has a synchronous clear and a sticky flag
// that records a dropped request.
//
// Handshake: IN_EN_ENQ and IN_EN_DEQ are requests. OUT_NOT_FULL and
// OUT_NOT_EMPTY play the role of ready and valid.
//   - A dequeue fires at a rising edge when IN_EN_DEQ=1 and the FIFO holds at
//     least one entry. A dequeue never bypasses a same-cycle enqueue.
//   - An enqueue fires when IN_EN_ENQ=1 and the FIFO is not full.
//   - With PIPELINED=1 an enqueue also fires at full when a dequeue fires in
//     the same cycle.
//   - A request that does not fire is dropped and sets OUT_ERR.
//   - IN_EN_CLEAR overrides both requests in its cycle.
// OUT_NOT_FULL, OUT_NOT_EMPTY, OUT_COUNT and OUT_ERR depend only on
// registered state.
module reg_fifo #(
    parameter int  WIDTH     = 1,
    parameter int  DEPTH     = 2,
    parameter bit  PIPELINED = 1'b1,
    // WIDTH==0 still builds a 1-bit datapath so the ports stay legal.
    localparam int DW        = (WIDTH == 0) ? 1 : WIDTH,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [DW-1:0] IN_ENQ,
    input  logic          IN_EN_ENQ,
    output logic          OUT_NOT_FULL,
    output logic [DW-1:0] OUT_FIRST,
    input  logic          IN_EN_DEQ,
    output logic          OUT_NOT_EMPTY,
    input  logic          IN_EN_CLEAR,
    output logic [CW-1:0] OUT_COUNT,
    output logic          OUT_ERR
);

    // Pointer width; a one-entry FIFO still gets a 1-bit pointer that stays 0.
    localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [DW-1:0] mem [DEPTH];

    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;
    logic          err_r;

    logic          not_full;
    logic          not_empty;
    logic          deq_fire;
    logic          enq_fire;
    logic          err_set;
    logic [PW-1:0] head_next;
    logic [PW-1:0] tail_next;
    logic [CW-1:0] count_next;

    // Advance a pointer with an explicit wrap at DEPTH-1. This does not
    // assume a power-of-two depth.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Status flags and fire conditions derived from the registered count.
    always_comb begin
        not_full  = (count_r != DEPTH_C);
        not_empty = (count_r != '0);
        deq_fire  = IN_EN_DEQ & not_empty;
        if (PIPELINED) begin
            enq_fire = IN_EN_ENQ & (not_full | deq_fire);
        end else begin
            enq_fire = IN_EN_ENQ & not_full;
        end
        err_set = (IN_EN_ENQ & ~enq_fire) | (IN_EN_DEQ & ~not_empty);
    end

    // Next pointer and occupancy values. The count is unchanged when both
    // requests fire.
    always_comb begin
        head_next  = deq_fire ? ptr_inc(head_r) : head_r;
        tail_next  = enq_fire ? ptr_inc(tail_r) : tail_r;
        count_next = count_r;
        case ({enq_fire, deq_fire})
            2'b10:   count_next = count_r + CW'(1);
            2'b01:   count_next = count_r - CW'(1);
            default: count_next = count_r;
        endcase
    end

    // Control state: pointers, count and the sticky error flag. Clear wins
    // over everything except reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            err_r   <= 1'b0;
        end else if (IN_EN_CLEAR) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            err_r   <= 1'b0;
        end else begin
            head_r  <= head_next;
            tail_r  <= tail_next;
            count_r <= count_next;
            err_r   <= err_r | err_set;
        end
    end

    // Storage write. The array is deliberately left without a reset, and a
    // clear suppresses the write.
    always_ff @(posedge CLK) begin
        if (enq_fire && !IN_EN_CLEAR) begin
            mem[tail_r] <= IN_ENQ;
        end
    end

    // Outputs. The head word is read combinationally from storage.
    always_comb begin
        OUT_NOT_FULL  = not_full;
        OUT_NOT_EMPTY = not_empty;
        OUT_COUNT     = count_r;
        OUT_ERR       = err_r;
        OUT_FIRST     = mem[head_r];
    end

endmodule

// File: doc/reg_fifo.md
Name: reg_fifo

Overview:
- Parametrised successor to the single-register state primitives.
- Holds up to DEPTH words of WIDTH bits in FIFO order, with an optional pipelined full-path mode.
- Provides a synchronous clear, an occupancy count and a sticky misuse flag.
- Used wherever a lone enabled register is replaced by buffering between producer and consumer rules.

Parameters:
WIDTH, 1, data width in bits; WIDTH==0 builds 1-bit storage and ports (value ignored by users)
DEPTH, 2, number of entries; legal range 1..1024, need not be a power of two
PIPELINED, 1, 1 = enqueue accepted when full if dequeue fires same cycle; 0 = enqueue requires not-full
CW, derived localparam = clog2(DEPTH+1), width of OUT_COUNT

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  asynchronous active-high reset
IN_ENQ  input  WIDTH  enqueue data
IN_EN_ENQ  input  1  enqueue request
OUT_NOT_FULL  output  1  1 when count < DEPTH
OUT_FIRST  output  WIDTH  head entry, combinational from storage
IN_EN_DEQ  input  1  dequeue request
OUT_NOT_EMPTY  output  1  1 when count > 0
IN_EN_CLEAR  input  1  synchronous flush
OUT_COUNT  output  CW  current occupancy 0..DEPTH
OUT_ERR  output  1  sticky: an enqueue or dequeue was dropped

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (RST=1, any time, no clock needed):
  - head=0, tail=0, count=0, OUT_ERR=0.
  - Outputs: OUT_NOT_FULL=1, OUT_NOT_EMPTY=0, OUT_COUNT=0.
  - Storage array is not reset.
- State is head pointer, tail pointer and count register; full/empty derive from count, not from pointer comparison.
- Pointers wrap from DEPTH-1 to 0; no power-of-two shortcut.
- deq_fire = IN_EN_DEQ & (count>0).
- enq_fire:
  - PIPELINED=1: IN_EN_ENQ & ((count<DEPTH) | deq_fire).
  - PIPELINED=0: IN_EN_ENQ & (count<DEPTH).
- On enq_fire: mem[tail] <= IN_ENQ; tail advances.
- On deq_fire: head advances.
- Count update: count +1 on enq only, -1 on deq only, unchanged when both fire.
- Simultaneous enq+deq at count=0: deq does not fire (no bypass); enq fires; count becomes 1.
- Simultaneous enq+deq at count=DEPTH with PIPELINED=1: both fire; the old head is replaced in order; count stays DEPTH.
- Latency: enqueued data is visible on OUT_FIRST the cycle after enq_fire, at the earliest.
- OUT_FIRST = mem[head] always. Its value is defined only while OUT_NOT_EMPTY=1; the bench must not check it otherwise.
- Clear (IN_EN_CLEAR=1 at an edge):
  - head=tail=count=0, OUT_ERR=0.
  - Overrides same-cycle enq/deq: nothing is written, nothing is counted.
- OUT_ERR:
  - Set at an edge when IN_EN_ENQ=1 and enq_fire=0 (overflow drop).
  - Set at an edge when IN_EN_DEQ=1 and count=0 (underflow).
  - Stays set until RST or IN_EN_CLEAR.
  - Clear wins over a same-cycle set.
- DEPTH=1:
  - PIPELINED=1 behaves as a one-slot pipeline register.
  - PIPELINED=0 alternates full and empty.
- Outputs OUT_NOT_FULL, OUT_NOT_EMPTY, OUT_COUNT and OUT_ERR are registered or derived only from registered state; none depends combinationally on IN_EN_* inputs.

Test Plan:
- WIDTH=8, DEPTH=4: reset; enqueue 0x11,0x22,0x33,0x44 on consecutive cycles -> OUT_COUNT=4, OUT_NOT_FULL=0. Then dequeue 4 cycles -> OUT_FIRST 0x11,0x22,0x33,0x44 in order, then OUT_NOT_EMPTY=0, OUT_ERR=0.
- DEPTH=4, PIPELINED=1, full with 0x11..0x44: enq 0x55 with deq same cycle -> OUT_COUNT stays 4, OUT_FIRST=0x22, OUT_ERR=0. Repeat 6 times -> pointer wrap preserves order.
- DEPTH=4, PIPELINED=0, full: enq 0x55 with deq -> only deq fires, OUT_COUNT=3, OUT_ERR=1. After draining, 0x55 is absent from the sequence.
- Empty FIFO: deq request -> OUT_ERR=1, OUT_COUNT=0. Then IN_EN_CLEAR with simultaneous enq 0x77 -> OUT_COUNT=0, OUT_ERR=0.
- DEPTH=3 (non-power-of-two): 10 interleaved enq/deq with random gaps -> output sequence equals input sequence; OUT_COUNT never exceeds 3.
- Assert RST mid-cycle while count=2, with no clock edge -> OUT_COUNT=0 and OUT_NOT_EMPTY=0 immediately. After release, first enq 0x9A is the first dequeued value.
